shared_ram_bus_arbiter: RTL

//  Arbitrates two Z80-style CPU ports (A = main, B = sub) onto one shared 8-bit RAM.

---
 rtl/shared_ram_bus_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/shared_ram_bus_arbiter.sv
// Two-port (A = main CPU, B = sub CPU) arbiter onto one shared RAM.
// Drives the RAM strobes, the ls245 stage DIR/OEn controls and the per-CPU WAIT_n.
module shared_ram_bus_arbiter #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_cs_n,
  input  logic          a_rd_n,
  input  logic          a_wr_n,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_wait_n,
  input  logic          b_cs_n,
  input  logic          b_rd_n,
  input  logic          b_wr_n,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_wait_n,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic          xcvr_dir,
  output logic          xcvr_oen
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DATA,
    S_RELEASE
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  state_t        state;
  port_t         grant;
  port_t         last_grant;
  port_t         next_grant;
  logic          grant_wr;

  logic          a_req;
  logic          b_req;
  logic          a_is_wr;
  logic          b_is_wr;
  logic          a_served;
  logic          b_served;
  logic          grant_req;

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_wr;

  // A write strobe wins over a simultaneous read strobe.
  assign a_req   = ~a_cs_n & (~a_rd_n | ~a_wr_n);
  assign b_req   = ~b_cs_n & (~b_rd_n | ~b_wr_n);
  assign a_is_wr = ~a_wr_n;
  assign b_is_wr = ~b_wr_n;

  always_comb begin
    next_grant = PORT_A;
    if (a_req && b_req) begin
      if (last_grant == PORT_A) begin
        next_grant = PORT_B;
      end else begin
        next_grant = PORT_A;
      end
    end else if (b_req) begin
      next_grant = PORT_B;
    end
  end

  always_comb begin
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    sel_wr    = a_is_wr;
    if (next_grant == PORT_B) begin
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
      sel_wr    = b_is_wr;
    end
  end

  assign a_served  = ((state == S_DATA) || (state == S_RELEASE)) && (grant == PORT_A);
  assign b_served  = ((state == S_DATA) || (state == S_RELEASE)) && (grant == PORT_B);
  assign grant_req = (grant == PORT_A) ? a_req : b_req;

  assign a_wait_n = reset | ~a_req | a_served;
  assign b_wait_n = reset | ~b_req | b_served;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= PORT_A;
      last_grant <= PORT_B;
      grant_wr   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      xcvr_dir   <= 1'b0;
      xcvr_oen   <= 1'b1;
    end else begin
      ram_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (a_req || b_req) begin
            grant    <= next_grant;
            grant_wr <= sel_wr;
            ram_addr <= sel_addr;
            xcvr_dir <= sel_wr;
            xcvr_oen <= 1'b0;
            if (sel_wr) begin
              ram_wdata <= sel_wdata;
              ram_we    <= 1'b1;
            end
            state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          last_grant <= grant;
          state      <= S_DATA;
        end
        S_DATA: begin
          if (!grant_wr) begin
            if (grant == PORT_A) begin
              a_rdata <= ram_rdata;
            end else begin
              b_rdata <= ram_rdata;
            end
          end
          // DIR is held here and cleared one edge later, so it never moves
          // on the same edge that OEn goes inactive.
          xcvr_oen <= 1'b1;
          state    <= S_RELEASE;
        end
        S_RELEASE: begin
          xcvr_dir <= 1'b0;
          if (!grant_req) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
